// File: rtl/alu_control_pipe.sv
// ALU control decoder with a valid/ready handshake and a multi-cycle hold-off for MULT/DIV.
// Optional feature: define ALU_CTRL_ILLEGAL_TRAP_EN to enable the sticky illegal-opcode flag.
module alu_control_pipe #(
    parameter int SEL_W  = 4,
    parameter int MD_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       func_field,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] ALU_SEL,
    output logic             multi_cycle,
    output logic             illegal,
    output logic             illegal_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [SEL_W-1:0] alu_sel_q;
    logic             multi_q;
    logic             illegal_q;
    logic             out_valid_q;

    logic             accept_s;
    logic [5:0]       dec_s;
    logic [SEL_W-1:0] sel_d;
    logic             md_d;
    logic             illegal_d;

    // Returns {illegal, multi_cycle, code[3:0]} for one request.
    function automatic logic [5:0] decode_f(input logic [1:0] op, input logic [5:0] fn);
        logic [5:0] r;
        case (op)
            2'b00:   r = {1'b0, 1'b0, 4'b0010};
            2'b01:   r = {1'b0, 1'b0, 4'b0110};
            2'b11:   r = {1'b0, 1'b0, 4'b0001};
            2'b10: begin
                case (fn)
                    6'b100000: r = {1'b0, 1'b0, 4'b0010};
                    6'b100010: r = {1'b0, 1'b0, 4'b0110};
                    6'b100100: r = {1'b0, 1'b0, 4'b0000};
                    6'b100101: r = {1'b0, 1'b0, 4'b0001};
                    6'b100111: r = {1'b0, 1'b0, 4'b1100};
                    6'b101010: r = {1'b0, 1'b0, 4'b0111};
                    6'b011000: r = {1'b0, 1'b1, 4'b1000};
                    6'b011010: r = {1'b0, 1'b1, 4'b1001};
                    default:   r = {1'b1, 1'b0, 4'b1111};
                endcase
            end
            default: r = {1'b1, 1'b0, 4'b1111};
        endcase
        return r;
    endfunction

    // Handshake: in HOLD a new request is only taken while the current result drains.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            BUSY:    in_ready = 1'b0;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept_s = in_valid & in_ready;

    // Decode the incoming request into the values captured on acceptance.
    always_comb begin
        dec_s       = decode_f(ALUOp, func_field);
        sel_d       = '0;
        sel_d[3:0]  = dec_s[3:0];
        md_d        = dec_s[4];
        illegal_d   = dec_s[5];
        if (illegal_d) begin
            sel_d = '1;
        end else begin
            sel_d = sel_d;
        end
    end

    // Main FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            alu_sel_q   <= '0;
            multi_q     <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept_s) begin
                        alu_sel_q <= sel_d;
                        multi_q   <= md_d;
                        illegal_q <= illegal_d;
                        if (md_d) begin
                            state_q     <= BUSY;
                            cnt_q       <= MD_LAT_C;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= HOLD;
                            cnt_q       <= 4'd0;
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == HOLD) && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end else begin
                        state_q     <= state_q;
                        out_valid_q <= out_valid_q;
                    end
                end
                BUSY: begin
                    if (cnt_q <= 4'd1) begin
                        state_q     <= HOLD;
                        cnt_q       <= 4'd0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign ALU_SEL     = alu_sel_q;
    assign multi_cycle = multi_q;
    assign illegal     = illegal_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic sticky_q;

    // Sticky trap flag: set by any accepted illegal request, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (accept_s && illegal_d) begin
            sticky_q <= 1'b1;
        end else begin
            sticky_q <= sticky_q;
        end
    end

    assign illegal_sticky = sticky_q;
`else
    assign illegal_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed self-checking bench for alu_control_pipe (default parameters).
module tb_alu_control_pipe;

    localparam int SEL_W  = 4;
    localparam int MD_LAT = 4;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam logic STICKY_EXP = 1'b1;
`else
    localparam logic STICKY_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [5:0]       func_field;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] ALU_SEL;
    logic             multi_cycle;
    logic             illegal;
    logic             illegal_sticky;

    int total = 0;
    int bad   = 0;

    alu_control_pipe #(.SEL_W(SEL_W), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .func_field(func_field), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_SEL(ALU_SEL), .multi_cycle(multi_cycle),
        .illegal(illegal), .illegal_sticky(illegal_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ALUOp = 2'b00; func_field = 6'd0;
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (ALU_SEL !== 4'b0000) begin bad++; $display("FAIL rst_sel got=%b want=0000", ALU_SEL); end
        total++; if ({multi_cycle, illegal, illegal_sticky} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {multi_cycle, illegal, illegal_sticky}); end
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_ops();
        logic [1:0] ops [3];
        logic [3:0] exp [3];
        ops[0] = 2'b00; exp[0] = 4'b0010;
        ops[1] = 2'b01; exp[1] = 4'b0110;
        ops[2] = 2'b11; exp[2] = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1; in_valid = 1'b1; ALUOp = ops[i]; func_field = 6'b111111;
            tick();
            in_valid = 1'b0; ALUOp = 2'b10;
            total++; if (out_valid !== 1'b1 || ALU_SEL !== exp[i]) begin bad++; $display("FAIL single_op%0d got v=%b sel=%b want v=1 sel=%b", i, out_valid, ALU_SEL, exp[i]); end
            total++; if (multi_cycle !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL single_flags%0d got m=%b i=%b want 0 0", i, multi_cycle, illegal); end
            tick();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL single_drain%0d got v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fn  [5];
        logic [3:0] exp [5];
        fn[0] = 6'b100000; exp[0] = 4'b0010;
        fn[1] = 6'b100010; exp[1] = 4'b0110;
        fn[2] = 6'b100100; exp[2] = 4'b0000;
        fn[3] = 6'b100101; exp[3] = 4'b0001;
        fn[4] = 6'b101010; exp[4] = 4'b0111;
        out_ready = 1'b1; ALUOp = 2'b10;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; func_field = fn[i];
            tick();
            total++; if (out_valid !== 1'b1 || ALU_SEL !== exp[i]) begin bad++; $display("FAIL b2b%0d got v=%b sel=%b want v=1 sel=%b", i, out_valid, ALU_SEL, exp[i]); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got v=%b want 0", out_valid); end
    endtask

    task automatic test_multdiv(input logic [5:0] fn, input logic [3:0] exp);
        out_ready = 1'b1; in_valid = 1'b1; ALUOp = 2'b10; func_field = fn;
        tick();
        in_valid = 1'b1; func_field = 6'b100000;
        for (int i = 0; i < MD_LAT; i++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL md_busy%0d got rdy=%b v=%b want 0 0", i, in_ready, out_valid); end
            tick();
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || ALU_SEL !== exp) begin bad++; $display("FAIL md_result got v=%b sel=%b want v=1 sel=%b", out_valid, ALU_SEL, exp); end
        total++; if (multi_cycle !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL md_flags got m=%b i=%b want 1 0", multi_cycle, illegal); end
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL md_drain got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1; ALUOp = 2'b10; func_field = 6'b100110;
        tick();
        func_field = 6'b100000;
        total++; if (out_valid !== 1'b1 || ALU_SEL !== 4'b1111 || illegal !== 1'b1) begin bad++; $display("FAIL ill_result got v=%b sel=%b i=%b want 1 1111 1", out_valid, ALU_SEL, illegal); end
        total++; if (multi_cycle !== 1'b0) begin bad++; $display("FAIL ill_multi got=%b want=0", multi_cycle); end
        total++; if (illegal_sticky !== STICKY_EXP) begin bad++; $display("FAIL ill_sticky got=%b want=%b", illegal_sticky, STICKY_EXP); end
        tick();
        in_valid = 1'b0;
        total++; if (ALU_SEL !== 4'b0010 || illegal !== 1'b0) begin bad++; $display("FAIL ill_next got sel=%b i=%b want 0010 0", ALU_SEL, illegal); end
        total++; if (illegal_sticky !== STICKY_EXP) begin bad++; $display("FAIL ill_sticky_keep got=%b want=%b", illegal_sticky, STICKY_EXP); end
        tick();
        total++; if (illegal_sticky !== STICKY_EXP) begin bad++; $display("FAIL ill_sticky_idle got=%b want=%b", illegal_sticky, STICKY_EXP); end
    endtask

    task automatic test_hold_stall();
        out_ready = 1'b0; in_valid = 1'b1; ALUOp = 2'b10; func_field = 6'b100111;
        tick();
        func_field = 6'b101010;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || ALU_SEL !== 4'b1100 || in_ready !== 1'b0) begin bad++; $display("FAIL stall%0d got v=%b sel=%b rdy=%b want 1 1100 0", i, out_valid, ALU_SEL, in_ready); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || ALU_SEL !== 4'b1100) begin bad++; $display("FAIL stall_release got rdy=%b sel=%b want 1 1100", in_ready, ALU_SEL); end
        tick();
        total++; if (out_valid !== 1'b0 || ALU_SEL !== 4'b1100) begin bad++; $display("FAIL stall_drain got v=%b sel=%b want 0 1100", out_valid, ALU_SEL); end
    endtask

    task automatic test_reset_mid_busy();
        out_ready = 1'b1; in_valid = 1'b1; ALUOp = 2'b10; func_field = 6'b011010;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || ALU_SEL !== 4'b0000 || in_ready !== 1'b1) begin bad++; $display("FAIL rstbusy_async got v=%b sel=%b rdy=%b want 0 0000 1", out_valid, ALU_SEL, in_ready); end
        total++; if ({multi_cycle, illegal, illegal_sticky} !== 3'b000) begin bad++; $display("FAIL rstbusy_flags got=%b want=000", {multi_cycle, illegal, illegal_sticky}); end
        tick(); tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < MD_LAT + 2; i++) begin
            tick();
            total++; if (out_valid !== 1'b0 || ALU_SEL !== 4'b0000 || in_ready !== 1'b1) begin bad++; $display("FAIL rstbusy_after%0d got v=%b sel=%b rdy=%b want 0 0000 1", i, out_valid, ALU_SEL, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_multdiv(6'b011000, 4'b1000);
        test_multdiv(6'b011010, 4'b1001);
        test_illegal();
        test_hold_stall();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
